// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the decode-stage hazard scoreboard.
//   - sb_entry_t : one in-flight writer record (valid, writes RF, rd, load, flag write)
//   - FWD_RF     : forwarding select value meaning "use the register-file value"
//   - depth_legal / reg_aw_legal : elaboration-time parameter checks
//   Register numbers are stored zero-extended to RD_W_MAX bits so the struct
//   does not depend on the REG_AW parameter of the instantiating module.
package hazard_pkg;

  localparam int unsigned RD_W_MAX  = 8;
  localparam int unsigned DEPTH_MIN = 2;
  localparam int unsigned DEPTH_MAX = 6;
  localparam int unsigned FWD_RF    = 0;

  typedef struct packed {
    logic                v;   // slot holds a real instruction
    logic                wr;  // instruction writes the register file
    logic [RD_W_MAX-1:0] rd;  // destination register (zero-extended)
    logic                ld;  // result only available at the end of MEM
    logic                fw;  // instruction writes flags in EX
  } sb_entry_t;

  function automatic logic depth_legal(input int unsigned d);
    return (d >= DEPTH_MIN) && (d <= DEPTH_MAX);
  endfunction

  function automatic logic reg_aw_legal(input int unsigned w);
    return (w >= 32'd1) && (w <= RD_W_MAX);
  endfunction

endpackage

// File: rtl/sb_match.sv
// sb_match
//   Combinational priority match of one source operand against the
//   scoreboard. The youngest (lowest-index) matching slot wins.
//   Ports:
//     src_i   source register number
//     used_i  the operand is actually read
//     wr_i    per-slot "real writer" (valid, writes RF, rd != 0)
//     rd_i    per-slot destination registers, slot i at [i*RD_W +: RD_W]
//     ld_i    per-slot load flag
//     hit_o   some slot matches
//     idx_o   index of the youngest matching slot
//     ld_o    the youngest matching slot holds a load
module sb_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RD_W  = 8,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic [RD_W-1:0]       src_i,
  input  logic                  used_i,
  input  logic [DEPTH-1:0]      wr_i,
  input  logic [DEPTH*RD_W-1:0] rd_i,
  input  logic [DEPTH-1:0]      ld_i,
  output logic                  hit_o,
  output logic [SEL_W-1:0]      idx_o,
  output logic                  ld_o
);

  // Priority search: scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    hit_o = 1'b0;
    idx_o = {SEL_W{1'b0}};
    ld_o  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (used_i && wr_i[i] && (rd_i[i*RD_W +: RD_W] == src_i)) begin
        hit_o = 1'b1;
        idx_o = SEL_W'(i);
        ld_o  = ld_i[i];
      end else begin
        // no match here: any older match already recorded stays selected
        hit_o = hit_o;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage hazard and forwarding unit built on a shift register of
//   in-flight writers (slot 0 = EX ... slot DEPTH-1 = WB).
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     id_valid                 ID holds a real instruction
//     id_src1/2, id_src1/2_used source operands and whether they are read
//     id_rd, id_rf_wr          destination and RF write enable
//     id_is_load               result available only after MEM
//     id_flag_wr               writes flags in EX
//     id_br_flags              conditional branch reading flags in ID
//     id_br_reg                branch reading id_src1 in ID
//     pipe_hold                external freeze; scoreboard holds, stall forced low
//     stall                    freeze PC/IF-ID and insert an ID/EX bubble
//     fwd_sel1/2               0 = RF value, k = forward from slot k-1
//   Optional build macro HAZARD_STATS_EN adds saturating 32-bit counters
//   cnt_load_use, cnt_flag, cnt_br_reg counting cycles each cause drives stall.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src1_used,
  input  logic              id_src2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rf_wr,
  input  logic              id_is_load,
  input  logic              id_flag_wr,
  input  logic              id_br_flags,
  input  logic              id_br_reg,
  input  logic              pipe_hold,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel1,
  output logic [SEL_W-1:0]  fwd_sel2
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       cnt_load_use,
  output logic [31:0]       cnt_flag,
  output logic [31:0]       cnt_br_reg
`endif
);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("hazard_scoreboard: DEPTH must be in 2..6");
  end
  if (!reg_aw_legal(REG_AW)) begin : g_bad_aw
    $error("hazard_scoreboard: REG_AW must be in 1..8");
  end

  sb_entry_t sb_q [DEPTH];
  sb_entry_t sb_d [DEPTH];

  logic [DEPTH-1:0]          wr_vec_s;
  logic [DEPTH*RD_W_MAX-1:0] rd_vec_s;
  logic [DEPTH-1:0]          ld_vec_s;

  logic             m1_hit_s, m1_ld_s, m2_hit_s, m2_ld_s;
  logic [SEL_W-1:0] m1_idx_s, m2_idx_s;
  logic             lu_s, fl_s, br_s, gate_s;

  // A matching slot forwards unless it is the WB slot (RF bypass covers it)
  // or a load still in EX (its data does not exist yet).
  function automatic logic [SEL_W-1:0] fwd_of(input logic hit, input logic [SEL_W-1:0] idx,
                                               input logic ld);
    if (hit && (idx != SEL_W'(DEPTH - 1)) && !((idx == {SEL_W{1'b0}}) && ld)) begin
      return idx + SEL_W'(1);
    end else begin
      return SEL_W'(FWD_RF);
    end
  endfunction

  // Flatten the scoreboard for the matchers; rd == 0 never counts as a writer.
  always_comb begin
    wr_vec_s = {DEPTH{1'b0}};
    rd_vec_s = {(DEPTH*RD_W_MAX){1'b0}};
    ld_vec_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      wr_vec_s[i] = sb_q[i].v & sb_q[i].wr & (sb_q[i].rd != {RD_W_MAX{1'b0}});
      rd_vec_s[i*RD_W_MAX +: RD_W_MAX] = sb_q[i].rd;
      ld_vec_s[i] = sb_q[i].ld;
    end
  end

  sb_match #(.DEPTH(DEPTH), .RD_W(RD_W_MAX), .SEL_W(SEL_W)) u_match1 (
    .src_i (RD_W_MAX'(id_src1)),
    .used_i(id_src1_used),
    .wr_i  (wr_vec_s),
    .rd_i  (rd_vec_s),
    .ld_i  (ld_vec_s),
    .hit_o (m1_hit_s),
    .idx_o (m1_idx_s),
    .ld_o  (m1_ld_s)
  );

  sb_match #(.DEPTH(DEPTH), .RD_W(RD_W_MAX), .SEL_W(SEL_W)) u_match2 (
    .src_i (RD_W_MAX'(id_src2)),
    .used_i(id_src2_used),
    .wr_i  (wr_vec_s),
    .rd_i  (rd_vec_s),
    .ld_i  (ld_vec_s),
    .hit_o (m2_hit_s),
    .idx_o (m2_idx_s),
    .ld_o  (m2_ld_s)
  );

  // Hazard causes and the resulting stall / forwarding selects.
  always_comb begin
    lu_s   = (m1_hit_s & (m1_idx_s == {SEL_W{1'b0}}) & m1_ld_s)
           | (m2_hit_s & (m2_idx_s == {SEL_W{1'b0}}) & m2_ld_s);
    fl_s   = id_br_flags & sb_q[0].v & sb_q[0].fw;
    // BR reads the register in ID: anything younger than WB is not yet in the RF
    br_s   = id_br_reg & m1_hit_s & (m1_idx_s <= SEL_W'(DEPTH - 2));
    gate_s = id_valid & ~pipe_hold;
    stall  = gate_s & (lu_s | fl_s | br_s);
    if (id_valid && !stall) begin
      fwd_sel1 = fwd_of(m1_hit_s, m1_idx_s, m1_ld_s);
      fwd_sel2 = fwd_of(m2_hit_s, m2_idx_s, m2_ld_s);
    end else begin
      fwd_sel1 = SEL_W'(FWD_RF);
      fwd_sel2 = SEL_W'(FWD_RF);
    end
  end

  // Next scoreboard contents: shift toward WB, enter ID or a bubble at slot 0.
  always_comb begin
    sb_d[0] = '0;
    if (id_valid && !stall) begin
      sb_d[0].v  = 1'b1;
      sb_d[0].wr = id_rf_wr;
      sb_d[0].rd = RD_W_MAX'(id_rd);
      sb_d[0].ld = id_is_load;
      sb_d[0].fw = id_flag_wr;
    end else begin
      sb_d[0] = '0;
    end
    for (int i = 1; i < DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  // Scoreboard register: reset beats hold, hold freezes every slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= '0;
      end
    end else if (!pipe_hold) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= sb_d[i];
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] cnt_lu_q, cnt_fl_q, cnt_br_q;

  // Saturating per-cause stall-cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lu_q <= 32'd0;
      cnt_fl_q <= 32'd0;
      cnt_br_q <= 32'd0;
    end else begin
      if (gate_s && lu_s && (cnt_lu_q != 32'hFFFF_FFFF)) cnt_lu_q <= cnt_lu_q + 32'd1;
      if (gate_s && fl_s && (cnt_fl_q != 32'hFFFF_FFFF)) cnt_fl_q <= cnt_fl_q + 32'd1;
      if (gate_s && br_s && (cnt_br_q != 32'hFFFF_FFFF)) cnt_br_q <= cnt_br_q + 32'd1;
    end
  end

  assign cnt_load_use = cnt_lu_q;
  assign cnt_flag     = cnt_fl_q;
  assign cnt_br_reg   = cnt_br_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int D  = 3;
  localparam int AW = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid, id_src1_used, id_src2_used, id_rf_wr, id_is_load;
  logic          id_flag_wr, id_br_flags, id_br_reg, pipe_hold;
  logic [AW-1:0] id_src1, id_src2, id_rd;
  logic          stall;
  logic [SW-1:0] fwd_sel1, fwd_sel2;
`ifdef HAZARD_STATS_EN
  logic [31:0]   cnt_load_use, cnt_flag, cnt_br_reg;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(AW), .DEPTH(D), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .id_rd(id_rd), .id_rf_wr(id_rf_wr), .id_is_load(id_is_load),
    .id_flag_wr(id_flag_wr), .id_br_flags(id_br_flags), .id_br_reg(id_br_reg),
    .pipe_hold(pipe_hold), .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
`ifdef HAZARD_STATS_EN
    , .cnt_load_use(cnt_load_use), .cnt_flag(cnt_flag), .cnt_br_reg(cnt_br_reg)
`endif
  );

  // ---------------- behavioural model: list of in-flight instructions ----------------
  typedef struct {
    bit       v;
    bit       wr;
    bit [3:0] rd;
    bit       ld;
    bit       fw;
  } rec_t;

  rec_t inflight [D];   // [0] = just issued (EX), [D-1] = WB
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  // Age of the most recent in-flight writer of src, or -1.
  function automatic int youngest(input bit [3:0] src, input bit used);
    if (!used || src == 4'd0) return -1;
    for (int k = 0; k < D; k++)
      if (inflight[k].v && inflight[k].wr && inflight[k].rd == src) return k;
    return -1;
  endfunction

  function automatic bit exp_stall();
    int  y1, y2;
    bit  lu, fl, br;
    y1 = youngest(id_src1, id_src1_used);
    y2 = youngest(id_src2, id_src2_used);
    lu = inflight[0].ld && (y1 == 0 || y2 == 0);
    fl = id_br_flags && inflight[0].v && inflight[0].fw;
    br = id_br_reg && y1 >= 0 && y1 <= D - 2;
    return id_valid && !pipe_hold && (lu || fl || br);
  endfunction

  function automatic int exp_sel(input int y);
    if (!id_valid || exp_stall()) return 0;
    if (y < 0 || y == D - 1) return 0;
    if (y == 0 && inflight[0].ld) return 0;
    return y + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model advances on the same edge as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) inflight[k] = '{0, 0, 0, 0, 0};
    end else if (!pipe_hold) begin
      bit s;
      s = exp_stall();
      for (int k = D - 1; k > 0; k--) inflight[k] = inflight[k-1];
      if (id_valid && !s)
        inflight[0] = '{1, id_rf_wr, id_rd, id_is_load, id_flag_wr};
      else
        inflight[0] = '{0, 0, 0, 0, 0};
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("model_stall", 32'(stall), 32'(exp_stall()));
      chk("model_sel1", 32'(fwd_sel1), 32'(exp_sel(youngest(id_src1, id_src1_used))));
      chk("model_sel2", 32'(fwd_sel2), 32'(exp_sel(youngest(id_src2, id_src2_used))));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nop();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_src1_used = 0; id_src2_used = 0;
    id_rd = 0; id_rf_wr = 0; id_is_load = 0; id_flag_wr = 0; id_br_flags = 0; id_br_reg = 0;
  endtask

  task automatic ins(input bit [3:0] rd, input bit [3:0] s1, input bit [3:0] s2,
                     input bit u1, input bit u2, input bit wr, input bit ld,
                     input bit fw, input bit bf, input bit br);
    id_valid = 1; id_rd = rd; id_src1 = s1; id_src2 = s2; id_src1_used = u1;
    id_src2_used = u2; id_rf_wr = wr; id_is_load = ld; id_flag_wr = fw;
    id_br_flags = bf; id_br_reg = br;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (D) nxt();
  endtask

  initial begin
    nop();
    pipe_hold = 0;
    repeat (2) nxt();
    rst = 0;
    chk_en = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_sel1", 32'(fwd_sel1), 32'd0);
    chk("rst_sel2", 32'(fwd_sel2), 32'd0);
    nxt();

    // ADD r3 ; SUB r4,r3,r2 ; two more readers of r3
    ins(3, 1, 2, 1, 1, 1, 0, 0, 0, 0); @(negedge clk); chk("add_stall", 32'(stall), 32'd0); nxt();
    ins(4, 3, 2, 1, 1, 1, 0, 0, 0, 0); @(negedge clk);
    chk("ex_fwd_sel1", 32'(fwd_sel1), 32'd1); chk("ex_fwd_sel2", 32'(fwd_sel2), 32'd0);
    chk("ex_fwd_stall", 32'(stall), 32'd0); nxt();
    ins(0, 3, 0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk); chk("mem_fwd_sel1", 32'(fwd_sel1), 32'd2); nxt();
    @(negedge clk); chk("wb_bypass_sel1", 32'(fwd_sel1), 32'd0); nxt();
    drain();

    // LW r5 ; ADD r6,r5,r1
    ins(5, 0, 0, 0, 0, 1, 1, 0, 0, 0); nxt();
    ins(6, 5, 1, 1, 1, 1, 0, 0, 0, 0); @(negedge clk);
    chk("lu_stall", 32'(stall), 32'd1); chk("lu_sel1_stalled", 32'(fwd_sel1), 32'd0); nxt();
    @(negedge clk); chk("lu_release", 32'(stall), 32'd0); chk("lu_sel1", 32'(fwd_sel1), 32'd2); nxt();
    drain();

    // flag writer then conditional branch; unrelated op then branch
    ins(8, 1, 2, 1, 1, 1, 0, 1, 0, 0); nxt();
    ins(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); @(negedge clk); chk("flag_stall", 32'(stall), 32'd1); nxt();
    @(negedge clk); chk("flag_release", 32'(stall), 32'd0); nxt();
    drain();
    ins(9, 1, 2, 1, 1, 1, 0, 0, 0, 0); nxt();
    ins(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); @(negedge clk); chk("noflag_stall", 32'(stall), 32'd0); nxt();
    drain();

    // ADD r7 ; BR r7 : two stall cycles
    ins(7, 1, 2, 1, 1, 1, 0, 0, 0, 0); nxt();
    ins(0, 7, 0, 1, 0, 0, 0, 0, 0, 1); @(negedge clk); chk("br_stall0", 32'(stall), 32'd1); nxt();
    @(negedge clk); chk("br_stall1", 32'(stall), 32'd1); nxt();
    @(negedge clk); chk("br_release", 32'(stall), 32'd0); chk("br_sel1", 32'(fwd_sel1), 32'd0); nxt();
    drain();

    // writer of r0 then reader of r0
    ins(0, 1, 2, 1, 1, 1, 0, 0, 0, 0); nxt();
    ins(1, 0, 0, 1, 1, 1, 0, 0, 0, 0); @(negedge clk);
    chk("r0_stall", 32'(stall), 32'd0); chk("r0_sel1", 32'(fwd_sel1), 32'd0);
    chk("r0_sel2", 32'(fwd_sel2), 32'd0); nxt();
    drain();

    // pending load-use under pipe_hold
    ins(5, 0, 0, 0, 0, 1, 1, 0, 0, 0); nxt();
    ins(6, 5, 1, 1, 1, 1, 0, 0, 0, 0); pipe_hold = 1;
    @(negedge clk); chk("hold_stall0", 32'(stall), 32'd0); nxt();
    @(negedge clk); chk("hold_stall1", 32'(stall), 32'd0); nxt();
    pipe_hold = 0;
    @(negedge clk); chk("hold_resume", 32'(stall), 32'd1); nxt();
    @(negedge clk); chk("hold_after", 32'(stall), 32'd0); chk("hold_sel1", 32'(fwd_sel1), 32'd2); nxt();
    drain();

    // reset in the middle of a load-use stall
    ins(5, 0, 0, 0, 0, 1, 1, 0, 0, 0); nxt();
    ins(6, 5, 1, 1, 1, 1, 0, 0, 0, 0); @(negedge clk);
    chk("rlu_stall", 32'(stall), 32'd1);
`ifdef HAZARD_STATS_EN
    chk("cnt_lu_before", cnt_load_use, 32'd2);
`endif
    #1 rst = 1;
    nxt();
    rst = 0;
    @(negedge clk);
    chk("rlu_cleared", 32'(stall), 32'd0); chk("rlu_sel1", 32'(fwd_sel1), 32'd0);
`ifdef HAZARD_STATS_EN
    chk("cnt_lu_after", cnt_load_use, 32'd0);
`endif
    nxt();
    drain();

    // randomized traffic with small register numbers to provoke hazards
    repeat (1500) begin
      id_valid     = ($urandom % 4) != 0;
      id_src1      = AW'($urandom_range(0, 5));
      id_src2      = AW'($urandom_range(0, 5));
      id_src1_used = ($urandom % 4) != 0;
      id_src2_used = ($urandom % 2) != 0;
      id_rd        = AW'($urandom_range(0, 5));
      id_rf_wr     = ($urandom % 4) != 0;
      id_is_load   = ($urandom % 4) == 0;
      id_flag_wr   = ($urandom % 4) == 0;
      id_br_flags  = ($urandom % 6) == 0;
      id_br_reg    = ($urandom % 6) == 0;
      pipe_hold    = ($urandom % 8) == 0;
      rst          = ($urandom % 64) == 0;
      nxt();
    end
    rst = 0;
    pipe_hold = 0;
    nop();
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
